stage_if_prefetch: RTL and testbench
====================================

# stage_if_prefetch

Parametrised instruction-fetch stage with a prefetch queue. It replaces the single-PC, combinational-memory fetch with a request/response instruction-memory port, an in-order prefetch FIFO of `DEPTH` entries and a valid/ready handshake toward decode. It sits between the PC-redirect source (the branch resolution in EX) and the ID stage. It keeps fetching while decode stalls, and it discards all wrong-path work on a redirect.

## Interface
- `XLEN`, 32: address and PC width.
- `ILEN`, 32: instruction width.
- `DEPTH`, 4: prefetch FIFO entries; power of two, ≥2. This is also the maximum of queued plus outstanding fetches.
- `RESET_PC`, 0: PC loaded on reset.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `redirect_valid`  in  1  taken branch or jump; flush and refetch.
- `redirect_pc`  in  XLEN  redirect target; bits [1:0] ignored, treated as 0.
- `imem_req_valid`  out  1  fetch request.
- `imem_req_addr`  out  XLEN  fetch address, word-aligned.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_rsp_valid`  in  1  response; in order, at least 1 cycle after its request, at most 1 per cycle.
- `imem_rsp_data`  in  ILEN  fetched instruction.
- `out_valid`  out  1  instruction available to decode.
- `out_ready`  in  1  decode accepts; low means stall (replaces `pc_stall`).
- `out_instruction`  out  ILEN  FIFO head instruction.
- `out_pc`  out  XLEN  PC of `out_instruction`.

## Operation
- State held:
  - `fetch_pc`: next address to request.
  - FIFO of {pc, instruction}.
  - `outstanding`: requests issued, responses not yet returned; range 0..DEPTH.
  - `discard`: responses still to drop; range 0..DEPTH.
- Issue rule: `imem_req_valid` = !`redirect_valid` && (fifo_count + `outstanding` < DEPTH).
  - A pop in the same cycle does not free credit.
- Request fire (`imem_req_valid` && `imem_req_ready`):
  - `fetch_pc` ← `fetch_pc` + 4, modulo 2^XLEN; wrap to 0 is legal.
  - The issued PC is pushed into an internal PC tag queue, or it is recomputed.
- Response, `discard` = 0: push {PC of the oldest outstanding request, `imem_rsp_data`}.
- Response, `discard` > 0: drop the data and decrement `discard`.
- Every response decrements `outstanding`. A request fire and a response in the same cycle leave `outstanding` unchanged.
- Pop when `out_valid` && `out_ready`.
- Redirect, applied at the clock edge:
  - FIFO emptied.
  - `fetch_pc` ← {`redirect_pc`[XLEN-1:2], 2'b00}.
  - `discard` ← `outstanding` − (response this cycle ? 1 : 0).
  - The request in the redirect cycle is suppressed.
  - A response in the redirect cycle is dropped.
  - A pop in the redirect cycle completes normally.
  - Back-to-back redirects: the last one wins, and `discard` is recomputed each time.
- FIFO full: cannot overflow, because the credit rule reserves a slot for every outstanding request.
- FIFO empty: `out_valid` = 0; `out_instruction` and `out_pc` hold their last values.

## Timing
- Reset (asynchronous assert, any cycle, including mid-fetch or mid-discard):
  - `fetch_pc` = RESET_PC.
  - FIFO empty; `outstanding` = 0; `discard` = 0.
  - `out_valid` = 0; `imem_req_valid` = 0.
  - `imem_req_addr` = RESET_PC.
  - `out_instruction` = 0; `out_pc` = RESET_PC.
- The first request is asserted in the first cycle `reset_n` is high.
- `out_valid` rises the cycle after the response cycle; there is no bypass. Minimum request-to-`out_valid` latency is 2 cycles.
- Sustained throughput is 1 instruction/cycle when memory returns each response 1 cycle after its request and `out_ready` = 1.
- Redirect:
  - Redirect asserted in cycle t.
  - `out_valid` = 0 in t+1.
  - First request to the new PC is issued in t+1.
  - Earliest new-path `out_valid` is in t+3.
- `out_*` and `imem_req_addr` are driven from registers.
- `imem_req_valid` is combinational only from `redirect_valid` and internal registers.

## Structure
- `riscv_pkg`: XLEN, ILEN, RESET_PC defaults, and the `fetch_entry_t` typedef {pc, instruction}.
- Sub-module `fifo_sync`:
  - Parameters WIDTH and DEPTH.
  - Push/pop, `flush`, `count`, `full`, `empty`.
  - Wrap-around pointers with an extra MSB.
  - One instance for the fetch entries; an optional second instance (depth DEPTH) for PC tags.
- Counters are `$clog2(DEPTH+1)` bits wide.

## Test plan
- Reset release, memory with 1-cycle latency, `out_ready`=1: PCs 0x0, 0x4, 0x8… arrive one per cycle; first `out_valid` occurs 2 cycles after the first request.
- `out_ready`=0 for 10 cycles: exactly DEPTH=4 entries fill and `imem_req_valid` drops; releasing `out_ready` drains 0x0..0xC in order with no loss.
- Memory with 3-cycle latency and 3 outstanding requests; redirect to 0x100 (bits [1:0]=2'b11 supplied): 3 stale responses are dropped; next `out_pc`=0x100, then 0x104.
- Redirect in the same cycle as a response and a pop: the popped entry is consumed, the response is dropped, and `discard` equals the remaining outstanding count.
- `fetch_pc`=0xFFFF_FFFC: next request address is 0x0000_0000.
- `reset_n` asserted with 2 outstanding requests and a full FIFO: all outputs take reset values immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: default widths, reset PC and the fetch entry layout.
package riscv_pkg;

  localparam int RV_XLEN = 32;
  localparam int RV_ILEN = 32;
  localparam logic [RV_XLEN-1:0] RV_RESET_PC = '0;

  typedef struct packed {
    logic [RV_XLEN-1:0] pc;
    logic [RV_ILEN-1:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with wrap-around pointers (extra MSB distinguishes full from empty).
module fifo_sync #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      used;
  logic             do_push;
  logic             do_pop;

  assign used    = wr_ptr_q - rd_ptr_q;
  assign count   = CW'(used);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer next-state: a flush empties the queue and overrides any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is written only on an accepted push and needs no reset.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/stage_if_prefetch.sv
// Instruction fetch stage: credit-limited memory requests, in-order prefetch queue,
// valid/ready toward decode, and wrong-path squashing on redirect.
module stage_if_prefetch
  import riscv_pkg::*;
#(
  parameter int              XLEN     = RV_XLEN,
  parameter int              ILEN     = RV_ILEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RV_RESET_PC)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instruction,
  output logic [XLEN-1:0] out_pc
);

  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instruction;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  entry_t          hold_q, hold_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  entry_t          push_entry;
  entry_t          head_entry;
  logic [CW:0]     inflight;
  logic            req_fire;
  logic            rsp_live;
  logic            unused_pc_bits;

  // Low address bits of a redirect target are don't-care; fetch is always word aligned.
  assign unused_pc_bits = ^redirect_pc[1:0];

  // A queue slot is reserved for every request in flight, so the queue can never overflow.
  assign inflight       = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign imem_req_valid = reset_n && !redirect_valid && !fifo_full &&
                          (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_live = imem_rsp_valid && (outstanding_q != '0);

  // With no responses left to drop, the oldest live request's PC sits 4*outstanding behind fetch_pc.
  assign push_entry.pc          = fetch_pc_q - (XLEN'(outstanding_q) << 2);
  assign push_entry.instruction = imem_rsp_data;
  assign fifo_push = rsp_live && (discard_q == '0) && !redirect_valid;
  assign fifo_pop  = out_valid && out_ready;

  assign out_valid       = !fifo_empty;
  assign out_pc          = fifo_empty ? hold_q.pc          : head_entry.pc;
  assign out_instruction = fifo_empty ? hold_q.instruction : head_entry.instruction;

  fifo_sync #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (redirect_valid),
    .wdata   (push_entry),
    .rdata   (head_entry),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next fetch PC, in-flight and discard bookkeeping; a redirect overrides normal advance.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    hold_d        = hold_q;

    if (!fifo_empty) hold_d = head_entry;

    if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);

    case ({req_fire, rsp_live})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (rsp_live && (discard_q != '0)) discard_d = discard_q - CW'(1);

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      discard_d  = outstanding_q - CW'(rsp_live);
    end
  end

  // Fetch-stage state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      hold_q        <= '{pc: RESET_PC, instruction: '0};
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      hold_q        <= hold_d;
    end
  end

endmodule

// File: tb/tb_stage_if_prefetch.sv
// Directed bench for stage_if_prefetch with a behavioural in-order instruction memory.
module tb_stage_if_prefetch;

  localparam logic [31:0] KEY = 32'h1357_9BDF;

  logic        clock;
  logic        reset_n;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        imemReqValid;
  logic [31:0] imemReqAddr;
  logic        imemReqReady;
  logic        imemRspValid;
  logic [31:0] imemRspData;
  logic        outValid;
  logic        outReady;
  logic [31:0] outInstruction;
  logic [31:0] outPc;

  int assertCount = 0;
  int failCount   = 0;
  int memLat      = 1;
  int memCycle    = 0;
  logic [31:0] reqAddrQ[$];
  int          reqCycQ[$];

  stage_if_prefetch #(
    .XLEN     (32),
    .ILEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .redirect_valid  (redirectValid),
    .redirect_pc     (redirectPc),
    .imem_req_valid  (imemReqValid),
    .imem_req_addr   (imemReqAddr),
    .imem_req_ready  (imemReqReady),
    .imem_rsp_valid  (imemRspValid),
    .imem_rsp_data   (imemRspData),
    .out_valid       (outValid),
    .out_ready       (outReady),
    .out_instruction (outInstruction),
    .out_pc          (outPc)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory bookkeeping: record this cycle's handshakes mid-cycle, away from the DUT edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      reqAddrQ.delete();
      reqCycQ.delete();
    end else begin
      if (imemRspValid && reqAddrQ.size() > 0) begin
        reqAddrQ.delete(0);
        reqCycQ.delete(0);
      end
      if (imemReqValid && imemReqReady) begin
        reqAddrQ.push_back(imemReqAddr);
        reqCycQ.push_back(memCycle);
      end
    end
    memCycle++;
  end

  // Memory response driver: oldest request answered once memLat cycles have elapsed.
  always @(posedge clock) begin
    #1;
    if (reset_n && reqAddrQ.size() > 0 && (reqCycQ[0] + memLat <= memCycle)) begin
      imemRspValid = 1'b1;
      imemRspData  = reqAddrQ[0] ^ KEY;
    end else begin
      imemRspValid = 1'b0;
      imemRspData  = '0;
    end
  end

  // Hard time limit so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #2;
  endtask

  task automatic applyStimulus(input logic redir, input logic [31:0] pc, input logic ready);
    redirectValid = redir;
    redirectPc    = pc;
    outReady      = ready;
    #1;
  endtask

  task automatic checkResetOutputs(input string pfx);
    checkOutput({pfx, "_out_valid"}, 32'(outValid), 32'h0);
    checkOutput({pfx, "_req_valid"}, 32'(imemReqValid), 32'h0);
    checkOutput({pfx, "_req_addr"},  imemReqAddr, 32'h0);
    checkOutput({pfx, "_out_instr"}, outInstruction, 32'h0);
    checkOutput({pfx, "_out_pc"},    outPc, 32'h0);
  endtask

  // Asserts reset, checks reset values, then releases mid-cycle; returns inside cycle 0.
  task automatic applyReset(input int lat, input logic ready);
    reset_n       = 1'b0;
    memLat        = lat;
    redirectValid = 1'b0;
    redirectPc    = '0;
    outReady      = ready;
    stepCycle();
    checkResetOutputs("rst");
    stepCycle();
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    reset_n       = 1'b0;
    redirectValid = 1'b0;
    redirectPc    = '0;
    imemReqReady  = 1'b1;
    imemRspValid  = 1'b0;
    imemRspData   = '0;
    outReady      = 1'b1;

    $display("[TB] streaming, 1-cycle memory");
    applyReset(1, 1'b1);
    checkOutput("s_c0_req_valid", 32'(imemReqValid), 32'h1);
    checkOutput("s_c0_req_addr",  imemReqAddr, 32'h0);
    checkOutput("s_c0_out_valid", 32'(outValid), 32'h0);
    stepCycle();
    checkOutput("s_c1_req_addr",  imemReqAddr, 32'h4);
    checkOutput("s_c1_out_valid", 32'(outValid), 32'h0);
    stepCycle();
    checkOutput("s_c2_out_valid", 32'(outValid), 32'h1);
    checkOutput("s_c2_out_pc",    outPc, 32'h0);
    checkOutput("s_c2_out_instr", outInstruction, KEY);
    checkOutput("s_c2_req_addr",  imemReqAddr, 32'h8);
    stepCycle();
    checkOutput("s_c3_out_pc",    outPc, 32'h4);
    checkOutput("s_c3_out_instr", outInstruction, KEY ^ 32'h4);
    stepCycle();
    checkOutput("s_c4_out_valid", 32'(outValid), 32'h1);
    checkOutput("s_c4_out_pc",    outPc, 32'h8);

    $display("[TB] decode stall and drain");
    applyReset(1, 1'b0);
    repeat (9) stepCycle();
    checkOutput("st_c9_req_valid", 32'(imemReqValid), 32'h0);
    checkOutput("st_c9_out_valid", 32'(outValid), 32'h1);
    checkOutput("st_c9_out_pc",    outPc, 32'h0);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("st_c10_req_valid_pop", 32'(imemReqValid), 32'h0);
    checkOutput("st_c10_out_pc",        outPc, 32'h0);
    stepCycle();
    checkOutput("st_c11_out_pc",    outPc, 32'h4);
    checkOutput("st_c11_req_valid", 32'(imemReqValid), 32'h1);
    checkOutput("st_c11_req_addr",  imemReqAddr, 32'h10);
    stepCycle();
    checkOutput("st_c12_out_pc", outPc, 32'h8);
    stepCycle();
    checkOutput("st_c13_out_pc",    outPc, 32'hC);
    checkOutput("st_c13_out_instr", outInstruction, KEY ^ 32'hC);
    stepCycle();
    checkOutput("st_c14_out_valid", 32'(outValid), 32'h1);
    checkOutput("st_c14_out_pc",    outPc, 32'h10);

    $display("[TB] redirect over 3 outstanding, 3-cycle memory");
    applyReset(3, 1'b1);
    repeat (3) stepCycle();
    applyStimulus(1'b1, 32'h0000_0103, 1'b1);
    checkOutput("r3_c3_req_valid", 32'(imemReqValid), 32'h0);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("r3_c4_out_valid", 32'(outValid), 32'h0);
    checkOutput("r3_c4_req_valid", 32'(imemReqValid), 32'h1);
    checkOutput("r3_c4_req_addr",  imemReqAddr, 32'h100);
    stepCycle();
    checkOutput("r3_c5_req_addr",  imemReqAddr, 32'h104);
    checkOutput("r3_c5_out_valid", 32'(outValid), 32'h0);
    stepCycle();
    checkOutput("r3_c6_out_valid", 32'(outValid), 32'h0);
    stepCycle();
    checkOutput("r3_c7_out_valid", 32'(outValid), 32'h0);
    stepCycle();
    checkOutput("r3_c8_out_valid", 32'(outValid), 32'h1);
    checkOutput("r3_c8_out_pc",    outPc, 32'h100);
    checkOutput("r3_c8_out_instr", outInstruction, KEY ^ 32'h100);
    stepCycle();
    checkOutput("r3_c9_out_pc", outPc, 32'h104);

    $display("[TB] redirect with same-cycle response and pop, 2-cycle memory");
    applyReset(2, 1'b1);
    repeat (3) stepCycle();
    checkOutput("rp_c3_out_valid", 32'(outValid), 32'h1);
    checkOutput("rp_c3_out_pc",    outPc, 32'h0);
    stepCycle();
    applyStimulus(1'b1, 32'h0000_0200, 1'b1);
    checkOutput("rp_c4_out_valid", 32'(outValid), 32'h1);
    checkOutput("rp_c4_out_pc",    outPc, 32'h4);
    checkOutput("rp_c4_rsp_valid", 32'(imemRspValid), 32'h1);
    checkOutput("rp_c4_req_valid", 32'(imemReqValid), 32'h0);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("rp_c5_out_valid", 32'(outValid), 32'h0);
    checkOutput("rp_c5_hold_pc",   outPc, 32'h4);
    checkOutput("rp_c5_hold_instr", outInstruction, KEY ^ 32'h4);
    checkOutput("rp_c5_req_valid", 32'(imemReqValid), 32'h1);
    checkOutput("rp_c5_req_addr",  imemReqAddr, 32'h200);
    stepCycle();
    checkOutput("rp_c6_out_valid", 32'(outValid), 32'h0);
    stepCycle();
    checkOutput("rp_c7_out_valid", 32'(outValid), 32'h0);
    stepCycle();
    checkOutput("rp_c8_out_valid", 32'(outValid), 32'h1);
    checkOutput("rp_c8_out_pc",    outPc, 32'h200);
    stepCycle();
    checkOutput("rp_c9_out_pc", outPc, 32'h204);

    $display("[TB] fetch address wrap");
    applyReset(1, 1'b1);
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
    checkOutput("w_c0_req_valid", 32'(imemReqValid), 32'h0);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("w_c1_req_valid", 32'(imemReqValid), 32'h1);
    checkOutput("w_c1_req_addr",  imemReqAddr, 32'hFFFF_FFFC);
    checkOutput("w_c1_out_valid", 32'(outValid), 32'h0);
    stepCycle();
    checkOutput("w_c2_req_addr",  imemReqAddr, 32'h0);
    checkOutput("w_c2_out_valid", 32'(outValid), 32'h0);
    stepCycle();
    checkOutput("w_c3_out_valid", 32'(outValid), 32'h1);
    checkOutput("w_c3_out_pc",    outPc, 32'hFFFF_FFFC);
    checkOutput("w_c3_out_instr", outInstruction, KEY ^ 32'hFFFF_FFFC);
    stepCycle();
    checkOutput("w_c4_out_pc",    outPc, 32'h0);
    checkOutput("w_c4_out_instr", outInstruction, KEY);

    $display("[TB] asynchronous reset mid-fetch");
    applyReset(3, 1'b0);
    repeat (5) stepCycle();
    checkOutput("mr_c5_out_valid", 32'(outValid), 32'h1);
    checkOutput("mr_c5_out_pc",    outPc, 32'h0);
    checkOutput("mr_c5_req_valid", 32'(imemReqValid), 32'h0);
    reset_n  = 1'b0;
    memLat   = 1;
    outReady = 1'b1;
    #1;
    checkResetOutputs("midrst");
    stepCycle();
    stepCycle();
    reset_n = 1'b1;
    #1;
    checkOutput("mr_rel_req_valid", 32'(imemReqValid), 32'h1);
    checkOutput("mr_rel_req_addr",  imemReqAddr, 32'h0);
    checkOutput("mr_rel_out_valid", 32'(outValid), 32'h0);
    stepCycle();
    checkOutput("mr_c1_req_addr", imemReqAddr, 32'h4);
    stepCycle();
    checkOutput("mr_c2_out_valid", 32'(outValid), 32'h1);
    checkOutput("mr_c2_out_pc",    outPc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
